// File: rtl/cache_arb_pkg.sv
// Shared types and line geometry for the cacheline port arbiter.
// Imported by cacheline_port_arbiter and cache_arb_perf.
package cache_arb_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } arb_owner_t;

endpackage

// File: rtl/cache_arb_perf.sv
// Saturating grant/contention counters for the cacheline port arbiter.
// Instantiated only when CACHE_ARB_PERF_CNT_EN is defined.
module cache_arb_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc_i,
    input  logic             i_inc_d,
    input  logic             i_inc_cont,
    output logic [CNT_W-1:0] o_i_grants,
    output logic [CNT_W-1:0] o_d_grants,
    output logic [CNT_W-1:0] o_contention
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_i_grants;
    logic [CNT_W-1:0] r_d_grants;
    logic [CNT_W-1:0] r_contention;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic en);
        return (en && (value != '1)) ? value + ONE : value;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_grants   <= '0;
            r_d_grants   <= '0;
            r_contention <= '0;
        end else begin
            r_i_grants   <= sat_inc(r_i_grants, i_inc_i);
            r_d_grants   <= sat_inc(r_d_grants, i_inc_d);
            r_contention <= sat_inc(r_contention, i_inc_cont);
        end
    end

    assign o_i_grants   = r_i_grants;
    assign o_d_grants   = r_d_grants;
    assign o_contention = r_contention;

endmodule

// File: rtl/cacheline_port_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between L1 icache and dcache.
// Define CACHE_ARB_PERF_CNT_EN to add saturating grant/contention counter outputs.
module cacheline_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = cache_arb_pkg::LINE_W,
    parameter int OFFSET_W = cache_arb_pkg::OFFSET_W
`ifdef CACHE_ARB_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
`ifdef CACHE_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_i_grants,
    output logic [CNT_W-1:0]  perf_d_grants,
    output logic [CNT_W-1:0]  perf_contention
`endif
);

    import cache_arb_pkg::*;

    arb_state_t r_state;
    arb_state_t w_next_state;
    arb_owner_t r_owner;
    arb_owner_t r_last_grant;
    arb_owner_t w_grant_owner;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant;
    logic              w_grant_write;
    logic              w_done;
    logic [ADDR_W-1:0] w_grant_addr;

    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;

    // Offset bits never reach memory; the line address is forced aligned.
    logic w_unused_offset_bits;
    assign w_unused_offset_bits = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0]};

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave it unassigned and infer a latch.
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = ICACHE;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = (r_last_grant == ICACHE) ? DCACHE : ICACHE;
                end else if (w_d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = DCACHE;
                end else if (w_i_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = ICACHE;
                end
                if (w_grant) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A dcache request with d_write set is a writeback even if d_read is also high.
    always_comb begin
        w_done        = (r_state == BUSY) && mem_resp;
        w_grant_write = (w_grant_owner == DCACHE) && d_write;
        w_grant_addr  = (w_grant_owner == DCACHE) ? d_addr : i_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= ICACHE;
            r_last_grant <= ICACHE;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
        end else begin
            r_i_resp <= w_done && (r_owner == ICACHE);
            r_d_resp <= w_done && (r_owner == DCACHE);
            if (w_grant) begin
                r_owner      <= w_grant_owner;
                r_last_grant <= w_grant_owner;
                r_mem_read   <= !w_grant_write;
                r_mem_write  <= w_grant_write;
                r_mem_addr   <= {w_grant_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                if (w_grant_write) begin
                    r_mem_wdata <= d_wdata;
                end
            end
            if (w_done) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                if (r_mem_read && (r_owner == ICACHE)) begin
                    r_i_rdata <= mem_rdata;
                end
                if (r_mem_read && (r_owner == DCACHE)) begin
                    r_d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_resp    = r_i_resp;
    assign d_resp    = r_d_resp;

    // Simultaneous dcache read and write is a requester bug; the write is still served.
    a_dcache_rw_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(d_read && d_write))
        else $warning("cacheline_port_arbiter: d_read and d_write both high, write served");

`ifdef CACHE_ARB_PERF_CNT_EN
    logic w_contention;
    assign w_contention = ((r_state == IDLE) && w_i_req && w_d_req) ||
                          ((r_state == BUSY) && ((r_owner == ICACHE) ? w_d_req : w_i_req));

    cache_arb_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_inc_i      (w_grant && (w_grant_owner == ICACHE)),
        .i_inc_d      (w_grant && (w_grant_owner == DCACHE)),
        .i_inc_cont   (w_contention),
        .o_i_grants   (perf_i_grants),
        .o_d_grants   (perf_d_grants),
        .o_contention (perf_contention)
    );
`endif

endmodule

// File: tb/tb_cacheline_port_arbiter.sv
// Directed bench for cacheline_port_arbiter: single reads/writes, round-robin ties,
// reset mid-transaction, spurious mem_resp, protocol error, and optional perf counters.
module tb_cacheline_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [LINE_W-1:0] PAT_A = {8{32'hA1A2_A3A4}};
    localparam logic [LINE_W-1:0] PAT_B = {8{32'hB0B1_B2B3}};
    localparam logic [LINE_W-1:0] PAT_C = {8{32'hC5C6_C7C8}};
    localparam logic [LINE_W-1:0] PAT_D = {8{32'hD0D0_0D0D}};
    localparam logic [LINE_W-1:0] PAT_E = {8{32'hE1E2_E3E4}};
    localparam logic [LINE_W-1:0] PAT_F = {8{32'hF00D_F00D}};
    localparam logic [LINE_W-1:0] PAT_G = {8{32'h1234_5678}};
    localparam logic [LINE_W-1:0] PAT_H = {8{32'hDEAD_BEEF}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
`ifdef CACHE_ARB_PERF_CNT_EN
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_contention;
    logic        sat_inc;
    logic [1:0]  sat_i;
    logic [1:0]  sat_d;
    logic [1:0]  sat_c;
`endif

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    cacheline_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
`ifdef CACHE_ARB_PERF_CNT_EN
        ,
        .perf_i_grants   (perf_i_grants),
        .perf_d_grants   (perf_d_grants),
        .perf_contention (perf_contention)
`endif
    );

`ifdef CACHE_ARB_PERF_CNT_EN
    cache_arb_perf #(
        .CNT_W (2)
    ) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_inc_i      (sat_inc),
        .i_inc_d      (sat_inc),
        .i_inc_cont   (sat_inc),
        .o_i_grants   (sat_i),
        .o_d_grants   (sat_d),
        .o_contention (sat_c)
    );
`endif

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [LINE_W-1:0] obs,
                              input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the arbiter to issue a memory op; returns cycles taken.
    task automatic wait_grant(input string tag, output int cycles);
        cycles = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            cycles++;
            if (mem_read || mem_write) break;
        end
        check_bit({tag, "_issued"}, mem_read | mem_write, 1'b1);
    endtask

    // Memory answers lat cycles after the op became visible.
    task automatic mem_ack(input string tag, input int latency, input logic [LINE_W-1:0] data);
        for (int k = 1; k < latency; k++) tick();
        check_bit({tag, "_held"}, mem_read | mem_write, 1'b1);
        mem_rdata = data;
        mem_resp  = 1'b1;
        tick();
        mem_resp  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
`ifdef CACHE_ARB_PERF_CNT_EN
        sat_inc   = 1'b0;
`endif
        tick();
        tick();
        check_bit("rst_mem_read", mem_read, 1'b0);
        check_bit("rst_mem_write", mem_write, 1'b0);
        check_word("rst_mem_addr", mem_addr, 32'h0);
        check_line("rst_mem_wdata", mem_wdata, '0);
        check_line("rst_i_rdata", i_rdata, '0);
        check_line("rst_d_rdata", d_rdata, '0);
        check_bit("rst_i_resp", i_resp, 1'b0);
        check_bit("rst_d_resp", d_resp, 1'b0);
        rst_n = 1'b1;
        tick();

        // icache line read, memory latency 3
        i_addr = 32'h0000_1234;
        i_read = 1'b1;
        wait_grant("t1", lat);
        check_word("t1_latency", 32'(lat), 32'd1);
        check_word("t1_addr", mem_addr, 32'h0000_1220);
        check_bit("t1_no_write", mem_write, 1'b0);
        mem_ack("t1", 3, PAT_A);
        check_bit("t1_i_resp", i_resp, 1'b1);
        check_bit("t1_d_resp", d_resp, 1'b0);
        check_line("t1_i_rdata", i_rdata, PAT_A);
        check_bit("t1_read_drop", mem_read, 1'b0);
        i_read = 1'b0;
        tick();
        check_bit("t1_i_resp_once", i_resp, 1'b0);

        // dcache writeback
        d_addr  = 32'h8000_00FF;
        d_wdata = PAT_B;
        d_write = 1'b1;
        wait_grant("t2", lat);
        check_word("t2_latency", 32'(lat), 32'd1);
        check_bit("t2_mem_write", mem_write, 1'b1);
        check_bit("t2_no_read", mem_read, 1'b0);
        check_word("t2_addr", mem_addr, 32'h8000_00E0);
        check_line("t2_wdata", mem_wdata, PAT_B);
        mem_ack("t2", 2, PAT_C);
        check_bit("t2_d_resp", d_resp, 1'b1);
        check_bit("t2_i_resp", i_resp, 1'b0);
        check_bit("t2_write_drop", mem_write, 1'b0);
        check_line("t2_d_rdata_kept", d_rdata, '0);
        check_line("t2_i_rdata_kept", i_rdata, PAT_A);
        d_write = 1'b0;
        tick();
        check_bit("t2_d_resp_once", d_resp, 1'b0);

        // Tie from reset: dcache first, then the waiting icache
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        i_addr = 32'h0000_4040;
        d_addr = 32'h0000_8080;
        i_read = 1'b1;
        d_read = 1'b1;
        wait_grant("t3a", lat);
        check_word("t3a_addr_dcache", mem_addr, 32'h0000_8080);
        mem_ack("t3a", 1, PAT_D);
        check_bit("t3a_d_resp", d_resp, 1'b1);
        check_bit("t3a_i_resp", i_resp, 1'b0);
        check_line("t3a_d_rdata", d_rdata, PAT_D);
        d_read = 1'b0;
        wait_grant("t3b", lat);
        check_word("t3b_latency", 32'(lat), 32'd2);
        check_word("t3b_addr_icache", mem_addr, 32'h0000_4040);
        mem_ack("t3b", 1, PAT_E);
        check_bit("t3b_i_resp", i_resp, 1'b1);
        check_bit("t3b_d_resp", d_resp, 1'b0);
        check_line("t3b_i_rdata", i_rdata, PAT_E);
        i_read = 1'b0;
        tick();

        // Four tie rounds: last grant was icache, so winners go D, I, D, I
        for (int r = 0; r < 4; r++) begin
            logic              exp_d;
            logic [ADDR_W-1:0] exp_addr;
            logic [LINE_W-1:0] pat;
            exp_d    = (r % 2 == 0);
            i_addr   = 32'h0001_0005 + 32'(r) * 32'h40;
            d_addr   = 32'h0002_0007 + 32'(r) * 32'h40;
            exp_addr = exp_d ? (32'h0002_0000 + 32'(r) * 32'h40)
                             : (32'h0001_0000 + 32'(r) * 32'h40);
            pat      = {8{32'h5500_0000 + 32'(r)}};
            i_read   = 1'b1;
            d_read   = 1'b1;
            wait_grant($sformatf("t4r%0d", r), lat);
            check_word($sformatf("t4r%0d_addr", r), mem_addr, exp_addr);
            mem_ack($sformatf("t4r%0d", r), 2, pat);
            check_bit($sformatf("t4r%0d_i_resp", r), i_resp, !exp_d);
            check_bit($sformatf("t4r%0d_d_resp", r), d_resp, exp_d);
            if (exp_d) check_line($sformatf("t4r%0d_d_rdata", r), d_rdata, pat);
            else       check_line($sformatf("t4r%0d_i_rdata", r), i_rdata, pat);
            i_read = 1'b0;
            d_read = 1'b0;
            tick();
        end

        // Request withdrawn while BUSY still completes
        i_addr = 32'h0000_2468;
        i_read = 1'b1;
        wait_grant("t5", lat);
        i_read = 1'b0;
        mem_ack("t5", 3, PAT_F);
        check_bit("t5_i_resp", i_resp, 1'b1);
        check_line("t5_i_rdata", i_rdata, PAT_F);
        tick();
        check_bit("t5_i_resp_once", i_resp, 1'b0);
        check_bit("t5_no_reissue", mem_read, 1'b0);

        // Reset while BUSY: outputs drop asynchronously, no resp
        d_addr = 32'h3000_0010;
        d_read = 1'b1;
        wait_grant("t6", lat);
        #2 rst_n = 1'b0;
        #1;
        check_bit("t6_async_read_low", mem_read, 1'b0);
        check_bit("t6_d_resp", d_resp, 1'b0);
        check_bit("t6_i_resp", i_resp, 1'b0);
        d_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_bit("t6_post_d_resp", d_resp, 1'b0);
        check_bit("t6_post_read", mem_read, 1'b0);
        d_addr = 32'h3000_0030;
        d_read = 1'b1;
        wait_grant("t6b", lat);
        check_word("t6b_latency", 32'(lat), 32'd1);
        check_word("t6b_addr", mem_addr, 32'h3000_0020);
        mem_ack("t6b", 4, PAT_G);
        check_bit("t6b_d_resp", d_resp, 1'b1);
        check_line("t6b_d_rdata", d_rdata, PAT_G);
        d_read = 1'b0;
        tick();

        // Spurious mem_resp in IDLE is ignored
        mem_rdata = PAT_H;
        mem_resp  = 1'b1;
        tick();
        mem_resp  = 1'b0;
        check_bit("t7_i_resp", i_resp, 1'b0);
        check_bit("t7_d_resp", d_resp, 1'b0);
        check_bit("t7_no_read", mem_read, 1'b0);
        check_line("t7_d_rdata_kept", d_rdata, PAT_G);
        tick();
        check_bit("t7_d_resp_later", d_resp, 1'b0);

        // d_read and d_write together: write is served
        d_addr  = 32'h4000_0000;
        d_wdata = PAT_E;
        d_read  = 1'b1;
        d_write = 1'b1;
        wait_grant("t8", lat);
        check_bit("t8_mem_write", mem_write, 1'b1);
        check_bit("t8_no_read", mem_read, 1'b0);
        check_line("t8_wdata", mem_wdata, PAT_E);
        mem_ack("t8", 1, PAT_C);
        check_bit("t8_d_resp", d_resp, 1'b1);
        check_line("t8_d_rdata_kept", d_rdata, PAT_G);
        d_read  = 1'b0;
        d_write = 1'b0;
        tick();

`ifdef CACHE_ARB_PERF_CNT_EN
        // Perf counters: one tie (D then I), then I, I, D -> 3 icache, 2 dcache grants
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_word("perf_rst_i", perf_i_grants, 32'd0);
        i_addr = 32'h0000_0100;
        d_addr = 32'h0000_0200;
        i_read = 1'b1;
        d_read = 1'b1;
        wait_grant("p1", lat);
        mem_ack("p1", 2, PAT_A);
        d_read = 1'b0;
        wait_grant("p2", lat);
        mem_ack("p2", 1, PAT_A);
        i_read = 1'b0;
        tick();
        for (int n = 0; n < 3; n++) begin
            if (n < 2) i_read = 1'b1;
            else       d_read = 1'b1;
            wait_grant($sformatf("p3n%0d", n), lat);
            mem_ack($sformatf("p3n%0d", n), 1, PAT_B);
            i_read = 1'b0;
            d_read = 1'b0;
            tick();
        end
        check_word("perf_i_grants", perf_i_grants, 32'd3);
        check_word("perf_d_grants", perf_d_grants, 32'd2);
        check_bit("perf_contention_nonzero", perf_contention != 32'd0, 1'b1);
        sat_inc = 1'b1;
        repeat (5) tick();
        sat_inc = 1'b0;
        tick();
        check_word("sat_i", 32'(sat_i), 32'd3);
        check_word("sat_d", 32'(sat_d), 32'd3);
        check_word("sat_c", 32'(sat_c), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
